mixer_route_scheduler: RTL and testbench
========================================

Name: mixer_route_scheduler

Overview:
- Time-shares one flow_switch route and its downstream mixer among N_SRC source requesters. This is the Source -> flow_switch -> Mixer path of the planar synthetic designs.
- Round-robin arbitration picks one requester. The block then sequences the job through five phases: switch settle, fill, mix, flush and completion.
- Drives switch select/valve controls and the mixer enable. Sits between the protocol controller and the valve driver layer.

Parameters:
- N_SRC, 4, number of requesting sources (2..16).
- SEL_W, $clog2(N_SRC), width of switch select.
- SETTLE_CYCLES, 2, switch settle time; must be >=1.
- FILL_CYCLES, 8, inlet valve open time; must be >=1.
- MIX_CYCLES, 16, mixer active time; must be >=1.
- FLUSH_CYCLES, 4, flush valve open time; must be >=1.
- CNT_W, 8, phase counter width; each *_CYCLES value must be <= 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req  in  N_SRC  per-source job request (level)
- abort  in  1  cancel the current job (sampled only in FILL/MIX)
- grant  out  N_SRC  one-hot owner of the route; zero when idle
- sw_sel  out  SEL_W  switch port select (index of the owning source)
- inlet_open  out  1  inlet valve open
- mix_en  out  1  mixer actuation
- flush_open  out  1  flush/outlet valve open
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at job end
- aborted  out  1  one-cycle pulse with done if the job was aborted

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state: all outputs 0, FSM=IDLE, rr_ptr=0, counter=0. Reset mid-job closes all valves and clears grant on the next edge. No flush occurs.
- State durations: IDLE, SETTLE (SETTLE_CYCLES), FILL (FILL_CYCLES), MIX (MIX_CYCLES), FLUSH (FLUSH_CYCLES), DONE (1 cycle). Each timed phase lasts exactly its parameter in cycles. The counter is loaded with N-1 on entry, and the phase exits on the cycle the counter is 0.
- IDLE: if req!=0, choose the first set bit searching upward from rr_ptr with wrap. Register the winner index, move to SETTLE. req==0 stays in IDLE.
- Requests are sampled only in IDLE. Changes to req during a job are ignored.
- Outputs per state:
  - grant and sw_sel are valid from SETTLE through DONE inclusive.
  - inlet_open=1 only in FILL.
  - mix_en=1 only in MIX.
  - flush_open=1 only in FLUSH.
  - busy=1 in every state except IDLE.
  - All outputs are registered (Moore).
- DONE: done=1 and grant is still held. rr_ptr becomes winner+1, wrapping to 0 at N_SRC. Next state is IDLE.
- Back-to-back jobs: the minimum gap is one IDLE cycle.
- Latency: req sampled in IDLE at cycle t gives grant at t+1 and done at t+SETTLE+FILL+MIX+FLUSH+1. With default parameters done is at t+31.
- abort: if abort=1 in FILL or MIX, move directly to FLUSH on the next edge. FLUSH still runs its full length. The DONE cycle then asserts done=1 and aborted=1.
- abort in SETTLE, FLUSH, DONE or IDLE is ignored.
- Invariants:
  - At most one of inlet_open, mix_en, flush_open is 1 at any time.
  - grant is one-hot or zero.
  - sw_sel never changes while busy.

Decomposition:
- Shared package mfda_ctrl_pkg:
  - state enum (IDLE, SETTLE, FILL, MIX, FLUSH, DONE);
  - phase-duration default constants;
  - valve-control struct {inlet_open, mix_en, flush_open}.
- Sub-module rr_arbiter:
  - combinational round-robin pick from req and rr_ptr;
  - outputs the one-hot grant and index;
  - reusable for other shared mixer/heater routes.
- The top module holds the FSM, phase counter and rr_ptr.

Test Plan:
- Reset during MIX (rst for 1 cycle) -> next cycle all outputs 0, busy=0. req=0001 afterwards -> grant=0001 one cycle after it is sampled.
- Single job, defaults, req=0100 at t -> grant=0100 and sw_sel=2 from t+1. inlet_open high for t+3..t+10, mix_en for t+11..t+26, flush_open for t+27..t+30. done at t+31, busy=0 at t+32.
- Round-robin fairness: req=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001. Successive done pulses are 32 cycles apart.
- Wrap and skip: rr_ptr=3 (after a source-2 job), req=0011 -> grant=0001. Next grant with req=0011 -> 0010.
- Abort in FILL at its 3rd cycle -> FLUSH starts the next cycle and lasts 4 cycles. done=1 and aborted=1 together. mix_en never asserts.
- Ignored changes: req changed 0001->1000 mid-job and abort pulsed during SETTLE -> grant stays 0001 and the job completes with aborted=0. The next job is granted to 1000.

Source files
------------

// File: rtl/mfda_ctrl_pkg.sv
// mfda_ctrl_pkg: shared FSM states, phase timing defaults and valve types for MFDA route controllers
package mfda_ctrl_pkg;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_FILL_CYCLES   = 8;
  localparam int DEF_MIX_CYCLES    = 16;
  localparam int DEF_FLUSH_CYCLES  = 4;
  typedef enum logic [2:0] {IDLE, SETTLE, FILL, MIX, FLUSH, DONE} state_t;
  typedef struct packed {
    logic inlet_open;
    logic mix_en;
    logic flush_open;
  } valve_t;
  function automatic valve_t valves_for(input state_t s);
    return '{inlet_open: s == FILL, mix_en: s == MIX, flush_open: s == FLUSH};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic         found;
  logic [W-1:0] j;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(ptr) + i >= N) ? int'(ptr) + i - N : int'(ptr) + i);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/mixer_route_scheduler.sv
// mixer_route_scheduler: round-robin time-sharing of one switch route and mixer through settle/fill/mix/flush/done
module mixer_route_scheduler
  import mfda_ctrl_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int SEL_W         = $clog2(N_SRC),
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int FILL_CYCLES   = DEF_FILL_CYCLES,
  parameter int MIX_CYCLES    = DEF_MIX_CYCLES,
  parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             abort,
  output logic [N_SRC-1:0] grant,
  output logic [SEL_W-1:0] sw_sel,
  output logic             inlet_open,
  output logic             mix_en,
  output logic             flush_open,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, sel_q, sel_d, arb_idx;
  logic [N_SRC-1:0] grant_q, grant_d, arb_gnt;
  valve_t           valve_q, valve_d;
  logic             busy_q, busy_d, done_q, done_d, ab_q, ab_d, aborted_q, aborted_d;
  logic             arb_valid, last, abort_hit;
  rr_arbiter #(.N(N_SRC), .W(SEL_W)) u_arb (
    .req  (req),
    .ptr  (rr_ptr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .valid(arb_valid)
  );
  function automatic logic [CNT_W-1:0] load(input int n);
    return CNT_W'(n - 1);
  endfunction
  always_comb begin
    last      = cnt_q == '0;
    abort_hit = abort && (state_q == FILL || state_q == MIX);
    state_d   = state_q;
    cnt_d     = last ? '0 : cnt_q - 1'b1;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      IDLE: if (arb_valid) begin
        state_d = SETTLE;
        cnt_d   = load(SETTLE_CYCLES);
      end
      SETTLE: if (last) begin
        state_d = FILL;
        cnt_d   = load(FILL_CYCLES);
      end
      FILL: if (abort_hit) begin
        state_d = FLUSH;
        cnt_d   = load(FLUSH_CYCLES);
      end else if (last) begin
        state_d = MIX;
        cnt_d   = load(MIX_CYCLES);
      end
      MIX: if (abort_hit || last) begin
        state_d = FLUSH;
        cnt_d   = load(FLUSH_CYCLES);
      end
      FLUSH: if (last) state_d = DONE;
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = (int'(sel_q) == N_SRC - 1) ? '0 : sel_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Owner is latched on leaving IDLE and held until the job returns there
    sel_d     = (state_d == IDLE) ? '0 : (state_q == IDLE) ? arb_idx : sel_q;
    grant_d   = (state_d == IDLE) ? '0 : (state_q == IDLE) ? arb_gnt : grant_q;
    ab_d      = (state_d == IDLE) ? 1'b0 : ab_q | abort_hit;
    valve_d   = valves_for(state_d);
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
    aborted_d = done_d & ab_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      valve_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ab_q      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valve_q   <= valve_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ab_q      <= ab_d;
      aborted_q <= aborted_d;
    end
  end
  assign grant      = grant_q;
  assign sw_sel     = sel_q;
  assign inlet_open = valve_q.inlet_open;
  assign mix_en     = valve_q.mix_en;
  assign flush_open = valve_q.flush_open;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
endmodule

// File: tb/tb_mixer_route_scheduler.sv
// tb_mixer_route_scheduler: directed jobs with per-cycle profile checks and a done-pulse scoreboard
module tb_mixer_route_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] grant;
  logic [1:0] sw_sel;
  logic       inlet_open, mix_en, flush_open, busy, done, aborted;
  int tests = 0, fails = 0, cyc = 0, start_cyc = 0;
  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       ab;
    int         dur;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic       busy_p = 1'b0;
  logic [1:0] sel_p = 2'b0;
  mixer_route_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort),
    .grant(grant), .sw_sel(sw_sel), .inlet_open(inlet_open), .mix_en(mix_en),
    .flush_open(flush_open), .busy(busy), .done(done), .aborted(aborted)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [11:0] nominal(input int k, input logic [3:0] g, input logic [1:0] s);
    logic b;
    b = k <= 31;
    return {b ? g : 4'b0, b ? s : 2'b0, k >= 3 && k <= 10, k >= 11 && k <= 26,
            k >= 27 && k <= 30, b, k == 31, 1'b0};
  endfunction
  function automatic logic [11:0] aborted_prof(input int k, input logic [3:0] g, input logic [1:0] s);
    logic b;
    b = k <= 10;
    return {b ? g : 4'b0, b ? s : 2'b0, k >= 3 && k <= 5, 1'b0, k >= 6 && k <= 9, b, k == 10, k == 10};
  endfunction
  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = {grant, sw_sel, inlet_open, mix_en, flush_open, busy, done, aborted};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got g=%b s=%0d in/mx/fl=%b busy=%b done=%b ab=%b, expected g=%b s=%0d in/mx/fl=%b busy=%b done=%b ab=%b",
               name, act[11:8], act[7:6], act[5:3], act[2], act[1], act[0],
               exp[11:8], exp[7:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic run_job(input logic [3:0] r, input logic [3:0] rm, input logic [3:0] g,
                         input logic [1:0] s, input logic ab_settle);
    req = r;
    sb.push_back('{g, s, 1'b0, 30});
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("job_g%b_k%0d", g, k), nominal(k, g, s));
      if (k == 1) begin
        req = rm;
        abort = ab_settle;
      end
      if (k == 2) abort = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    tests++;
    if (!$onehot0({inlet_open, mix_en, flush_open}) || !$onehot0(grant) ||
        (busy && busy_p && sw_sel !== sel_p)) begin
      fails++;
      $display("FAIL invariant cyc%0d: valves=%b grant=%b sel=%0d prev_sel=%0d",
               cyc, {inlet_open, mix_en, flush_open}, grant, sw_sel, sel_p);
    end
    if (busy && !busy_p) start_cyc = cyc;
    if (done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_done cyc%0d: got grant=%b, expected no done", cyc, grant);
      end else begin
        e = sb.pop_front();
        if ({grant, sw_sel, aborted} !== {e.g, e.s, e.ab} || cyc - start_cyc != e.dur) begin
          fails++;
          $display("FAIL sb_done cyc%0d: got grant=%b sel=%0d ab=%b dur=%0d, expected grant=%b sel=%0d ab=%b dur=%0d",
                   cyc, grant, sw_sel, aborted, cyc - start_cyc, e.g, e.s, e.ab, e.dur);
        end
      end
    end
    busy_p = busy;
    sel_p  = sw_sel;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 12'b0);
    rst = 1'b0;
    // fairness with all sources requesting
    run_job(4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b0);
    run_job(4'b1111, 4'b1111, 4'b0010, 2'd1, 1'b0);
    run_job(4'b1111, 4'b1111, 4'b0100, 2'd2, 1'b0);
    run_job(4'b1111, 4'b1111, 4'b1000, 2'd3, 1'b0);
    run_job(4'b1111, 4'b1111, 4'b0001, 2'd0, 1'b0);
    run_job(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    run_job(4'b0011, 4'b0011, 4'b0001, 2'd0, 1'b0);
    run_job(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b0);
    run_job(4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1);
    run_job(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    // abort in the third FILL cycle
    req = 4'b0001;
    sb.push_back('{4'b0001, 2'd0, 1'b1, 9});
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("abort_k%0d", k), aborted_prof(k, 4'b0001, 2'd0));
      if (k == 1) req = 4'b0000;
      abort = k == 5;
    end
    // reset in the middle of MIX
    req = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("prerst_k%0d", k), nominal(k, 4'b0010, 2'd1));
      if (k == 1) req = 4'b0000;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_mix", 12'b0);
    rst = 1'b0;
    run_job(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
